// File: rtl/stream_unpack16_pkg.sv
// Shared widths and helpers for the 64-bit to 16-bit stream unpacker.
// Consumers: stream_unpack16 (top) and bswap64 (byte reversal, only used
// when STREAM_UNPACK16_SWAP_EN is defined).
package stream_unpack16_pkg;

  localparam int WORD_W = 64;
  localparam int ELEM_W = 16;
  localparam int LANES  = 4;
  localparam int LANE_W = 2;
  localparam int BYTES  = WORD_W / 8;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [ELEM_W-1:0] elem_t;
  typedef logic [LANE_W-1:0] lane_t;

  localparam lane_t LAST_LANE = lane_t'(LANES - 1);

  // Lane 0 sits in the least significant 16 bits of the held word.
  function automatic elem_t laneSelect(input word_t word, input lane_t lane);
    return word[ELEM_W*int'(lane) +: ELEM_W];
  endfunction

endpackage

// File: rtl/bswap64.sv
// Purely combinational byte reversal of a 64-bit stream word:
// byte i of the result is byte (7-i) of the input.
// Instantiated by stream_unpack16 only when STREAM_UNPACK16_SWAP_EN is defined.
module bswap64
  import stream_unpack16_pkg::*;
(
  input  logic [WORD_W-1:0] data_i,
  output logic [WORD_W-1:0] data_o
);

  // Mirror byte order end-for-end
  always_comb begin
    data_o = '0;
    for (int i = 0; i < BYTES; i++) begin
      data_o[8*i +: 8] = data_i[8*(BYTES-1-i) +: 8];
    end
  end

endmodule

// File: rtl/stream_unpack16.sv
// Unpacks each accepted 64-bit word into four 16-bit elements, lane 0 first,
// tracking the element position within a frame of FRAME_ELEMS elements and
// flagging the final element with out_last.
// Optional feature: define STREAM_UNPACK16_SWAP_EN to byte-reverse every
// accepted word before it is split into lanes (same latency either way).
module stream_unpack16
  import stream_unpack16_pkg::*;
#(
  parameter int FRAME_ELEMS = 10752,
  parameter int CNT_W       = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic [WORD_W-1:0] in,
  input  logic              in_isReady,
  output logic              in_canReceive,
  output logic [ELEM_W-1:0] out,
  output logic              out_isReady,
  input  logic              out_canReceive,
  output logic              out_last
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_ELEMS - 1);

  word_t            wordIn;
  word_t            hold_q, hold_d;
  logic             holdValid_q, holdValid_d;
  lane_t            lane_q, lane_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             outXfer;
  logic             inXfer;
  logic             lastLane;

`ifdef STREAM_UNPACK16_SWAP_EN
  bswap64 u_bswap64 (
    .data_i (in),
    .data_o (wordIn)
  );
`else
  assign wordIn = in;
`endif

  // Handshakes; a new word may land in the same cycle the last lane drains,
  // and clear blocks acceptance outright.
  assign lastLane      = (lane_q == LAST_LANE);
  assign outXfer       = holdValid_q & out_canReceive;
  assign inXfer        = in_isReady & in_canReceive;
  assign in_canReceive = ~clear & (~holdValid_q | (lastLane & out_canReceive));

  // Outputs come straight from registers, so nothing on the input side
  // reaches out_isReady combinationally.
  assign out_isReady = holdValid_q;
  assign out         = laneSelect(hold_q, lane_q);
  assign out_last    = holdValid_q & (cnt_q == LAST_CNT);

  // Next-state: clear wins, otherwise advance on an out transfer and load on an in transfer
  always_comb begin
    hold_d      = hold_q;
    holdValid_d = holdValid_q;
    lane_d      = lane_q;
    cnt_d       = cnt_q;
    if (clear) begin
      holdValid_d = 1'b0;
      lane_d      = '0;
      cnt_d       = '0;
    end else begin
      if (outXfer) begin
        lane_d = lane_q + lane_t'(1);
        cnt_d  = (cnt_q == LAST_CNT) ? '0 : cnt_q + CNT_W'(1);
        if (lastLane) begin
          holdValid_d = 1'b0;
        end
      end
      if (inXfer) begin
        hold_d      = wordIn;
        holdValid_d = 1'b1;
        lane_d      = '0;
      end
    end
  end

  // State registers, cleared asynchronously so a mid-frame reset drops the held word
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_q      <= '0;
      holdValid_q <= 1'b0;
      lane_q      <= '0;
      cnt_q       <= '0;
    end else begin
      hold_q      <= hold_d;
      holdValid_q <= holdValid_d;
      lane_q      <= lane_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_stream_unpack16.sv
// Self-checking bench for stream_unpack16 with an 8-element frame.
// Honours STREAM_UNPACK16_SWAP_EN when building expected lane values.
module tb_stream_unpack16;

  localparam int FRAME = 8;
  localparam int CW    = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clear = 1'b0;
  logic [63:0] inWord = '0;
  logic        inIsReady = 1'b0;
  logic        in_canReceive;
  logic [15:0] out;
  logic        out_isReady;
  logic        outCanReceive = 1'b0;
  logic        out_last;

  int          nCompared = 0;
  int          nMismatched = 0;
  logic [16:0] sbQ[$];
  int          modelCnt = 0;

  stream_unpack16 #(.FRAME_ELEMS(FRAME), .CNT_W(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .clear          (clear),
    .in             (inWord),
    .in_isReady     (inIsReady),
    .in_canReceive  (in_canReceive),
    .out            (out),
    .out_isReady    (out_isReady),
    .out_canReceive (outCanReceive),
    .out_last       (out_last)
  );

  always #5 clk = ~clk;

  // Reference lane extraction, with optional byte reversal of the whole word
  function automatic logic [15:0] modelLane(input logic [63:0] w, input int k);
    logic [63:0] s;
    s = w;
`ifdef STREAM_UNPACK16_SWAP_EN
    for (int i = 0; i < 8; i++) s[8*i +: 8] = w[8*(7-i) +: 8];
`endif
    return s[16*k +: 16];
  endfunction

  // Scoreboard monitor: push four elements per accepted word, pop on each out transfer
  always @(negedge clk) begin
    logic [16:0] exp;
    if (rst) begin
      if (clear) begin
        sbQ.delete();
        modelCnt = 0;
      end else begin
        if (out_isReady && outCanReceive) begin
          nCompared++;
          if (sbQ.size() == 0) begin
            nMismatched++;
            $display("[TB] FAIL sb_underflow: got out=%h last=%b with nothing expected", out, out_last);
          end else begin
            exp = sbQ.pop_front();
            if ({out_last, out} !== exp) begin
              nMismatched++;
              $display("[TB] FAIL sb_element: got out=%h last=%b, required out=%h last=%b",
                       out, out_last, exp[15:0], exp[16]);
            end
          end
        end
        if (inIsReady && in_canReceive) begin
          for (int k = 0; k < 4; k++) begin
            sbQ.push_back({(modelCnt == FRAME-1), modelLane(inWord, k)});
            modelCnt = (modelCnt == FRAME-1) ? 0 : modelCnt + 1;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) until the offered word is taken; returns after the accepting edge
  task automatic waitAccept(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_canReceive) begin
        tick();
        ok = 1'b1;
        return;
      end
    end
  endtask

  // Wait (bounded) until the scoreboard has nothing outstanding
  task automatic drain(output bit ok);
    int n;
    n = 0;
    while (sbQ.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    ok = (sbQ.size() == 0);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    @(negedge clk);
    nCompared++;
    if (out_isReady !== 1'b0) begin nMismatched++; $display("[TB] FAIL rst_isReady: got %b required 0", out_isReady); end
    nCompared++;
    if (out_last !== 1'b0) begin nMismatched++; $display("[TB] FAIL rst_last: got %b required 0", out_last); end
    nCompared++;
    if (out !== 16'h0000) begin nMismatched++; $display("[TB] FAIL rst_out: got %h required 0000", out); end
    nCompared++;
    if (in_canReceive !== 1'b1) begin nMismatched++; $display("[TB] FAIL rst_canReceive: got %b required 1", in_canReceive); end
    #2 rst = 1'b1;
    tick();
    @(negedge clk);
    nCompared++;
    if (in_canReceive !== 1'b1) begin nMismatched++; $display("[TB] FAIL rel_canReceive: got %b required 1", in_canReceive); end
    tick();
  endtask

  task automatic test_basic();
    logic [15:0] exp[4];
    bit ok;
`ifdef STREAM_UNPACK16_SWAP_EN
    exp = '{16'h4444, 16'h3333, 16'h2222, 16'h1111};
`else
    exp = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
`endif
    outCanReceive = 1'b1;
    inWord = 64'h4444_3333_2222_1111;
    inIsReady = 1'b1;
    waitAccept(ok);
    inIsReady = 1'b0;
    nCompared++;
    if (ok !== 1'b1) begin nMismatched++; $display("[TB] FAIL basic_accept: got %b required 1", ok); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      nCompared++;
      if ({out_isReady, out} !== {1'b1, exp[i]}) begin
        nMismatched++;
        $display("[TB] FAIL basic_lane%0d: got valid=%b out=%h required valid=1 out=%h", i, out_isReady, out, exp[i]);
      end
      if (i == 3) begin
        nCompared++;
        if (in_canReceive !== 1'b1) begin nMismatched++; $display("[TB] FAIL basic_canReceive4: got %b required 1", in_canReceive); end
      end
      tick();
    end
    drain(ok);
    nCompared++;
    if (ok !== 1'b1) begin nMismatched++; $display("[TB] FAIL basic_drain: got %0d left required 0", sbQ.size()); end
  endtask

  task automatic test_swap();
    logic [15:0] exp[4];
    bit ok;
`ifdef STREAM_UNPACK16_SWAP_EN
    exp = '{16'h2301, 16'h6745, 16'hAB89, 16'hEFCD};
`else
    exp = '{16'hCDEF, 16'h89AB, 16'h4567, 16'h0123};
`endif
    outCanReceive = 1'b1;
    inWord = 64'h0123_4567_89AB_CDEF;
    inIsReady = 1'b1;
    waitAccept(ok);
    inIsReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      nCompared++;
      if (out !== exp[i]) begin
        nMismatched++;
        $display("[TB] FAIL swap_lane%0d: got %h required %h", i, out, exp[i]);
      end
      tick();
    end
    drain(ok);
    nCompared++;
    if (ok !== 1'b1) begin nMismatched++; $display("[TB] FAIL swap_drain: got %0d left required 0", sbQ.size()); end
  endtask

  task automatic test_frame_last();
    logic [63:0] words[4];
    int wi, seen, bubbles;
    int lastIdx[$];
    bit acc;
    words = '{64'hA003_A002_A001_A000, 64'hB003_B002_B001_B000,
              64'hC003_C002_C001_C000, 64'hD003_D002_D001_D000};
    clear = 1'b1;
    tick();
    clear = 1'b0;
    outCanReceive = 1'b1;
    wi = 0; seen = 0; bubbles = 0;
    inWord = words[0];
    inIsReady = 1'b1;
    for (int cyc = 0; cyc < 60 && seen < 16; cyc++) begin
      @(negedge clk);
      if (out_isReady) begin
        if (out_last) lastIdx.push_back(seen);
        seen++;
      end else if (seen > 0) begin
        bubbles++;
      end
      acc = inIsReady && in_canReceive;
      tick();
      if (acc) begin
        wi++;
        if (wi < 4) inWord = words[wi];
        else inIsReady = 1'b0;
      end
    end
    inIsReady = 1'b0;
    nCompared++;
    if (seen !== 16) begin nMismatched++; $display("[TB] FAIL frame_count: got %0d required 16", seen); end
    nCompared++;
    if (bubbles !== 0) begin nMismatched++; $display("[TB] FAIL frame_bubbles: got %0d required 0", bubbles); end
    nCompared++;
    if (lastIdx.size() !== 2) begin
      nMismatched++;
      $display("[TB] FAIL frame_lastCount: got %0d required 2", lastIdx.size());
    end else begin
      nCompared++;
      if (lastIdx[0] !== 7 || lastIdx[1] !== 15) begin
        nMismatched++;
        $display("[TB] FAIL frame_lastPos: got %0d,%0d required 7,15", lastIdx[0], lastIdx[1]);
      end
    end
    tick();
  endtask

  task automatic test_stall();
    logic [63:0] w1, w2;
    bit ok;
    w1 = 64'h1D1C_1B1A_1918_1716;
    w2 = 64'h2F2E_2D2C_2B2A_2928;
    outCanReceive = 1'b0;
    inWord = w1;
    inIsReady = 1'b1;
    waitAccept(ok);
    inWord = w2;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      nCompared++;
      if ({out_isReady, out} !== {1'b1, modelLane(w1, 0)}) begin
        nMismatched++;
        $display("[TB] FAIL stall_out%0d: got valid=%b out=%h required valid=1 out=%h", i, out_isReady, out, modelLane(w1, 0));
      end
      nCompared++;
      if (in_canReceive !== 1'b0) begin nMismatched++; $display("[TB] FAIL stall_canReceive%0d: got %b required 0", i, in_canReceive); end
      tick();
    end
    outCanReceive = 1'b1;
    waitAccept(ok);
    inIsReady = 1'b0;
    nCompared++;
    if (ok !== 1'b1) begin nMismatched++; $display("[TB] FAIL stall_resume: got %b required 1", ok); end
    drain(ok);
    nCompared++;
    if (ok !== 1'b1) begin nMismatched++; $display("[TB] FAIL stall_drain: got %0d left required 0", sbQ.size()); end
  endtask

  task automatic test_clear();
    logic [63:0] wA, wB, wC;
    int seen;
    int lastIdx[$];
    logic [15:0] firstOut;
    bit ok, acc;
    wA = 64'h3333_3222_3111_3000;
    wB = 64'h4B03_4B02_4B01_4B00;
    wC = 64'h4C03_4C02_4C01_4C00;
    outCanReceive = 1'b1;
    inWord = wA;
    inIsReady = 1'b1;
    waitAccept(ok);
    inIsReady = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tick();
    end
    clear = 1'b1;
    inWord = wB;
    inIsReady = 1'b1;
    @(negedge clk);
    nCompared++;
    if (in_canReceive !== 1'b0) begin nMismatched++; $display("[TB] FAIL clear_canReceive: got %b required 0", in_canReceive); end
    tick();
    clear = 1'b0;
    @(negedge clk);
    nCompared++;
    if (out_isReady !== 1'b0) begin nMismatched++; $display("[TB] FAIL clear_isReady: got %b required 0", out_isReady); end
    seen = 0;
    firstOut = '0;
    for (int cyc = 0; cyc < 40 && seen < 8; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (out_isReady) begin
        if (seen == 0) firstOut = out;
        if (out_last) lastIdx.push_back(seen);
        seen++;
      end
      acc = inIsReady && in_canReceive;
      tick();
      if (acc) begin
        if (inWord == wB) inWord = wC;
        else inIsReady = 1'b0;
      end
    end
    inIsReady = 1'b0;
    nCompared++;
    if (firstOut !== modelLane(wB, 0)) begin nMismatched++; $display("[TB] FAIL clear_first: got %h required %h", firstOut, modelLane(wB, 0)); end
    nCompared++;
    if (lastIdx.size() !== 1 || (lastIdx.size() == 1 && lastIdx[0] !== 7)) begin
      nMismatched++;
      $display("[TB] FAIL clear_lastPos: got %0d flags (first at %0d) required one at 7", lastIdx.size(), (lastIdx.size() > 0) ? lastIdx[0] : -1);
    end
    drain(ok);
  endtask

  task automatic test_reset_mid();
    logic [63:0] wD, wE;
    bit ok;
    wD = 64'h5D03_5D02_5D01_5D00;
    wE = 64'h6E03_6E02_6E01_6E00;
    outCanReceive = 1'b1;
    inWord = wD;
    inIsReady = 1'b1;
    waitAccept(ok);
    inIsReady = 1'b0;
    @(negedge clk);
    tick();
    #2 rst = 1'b0;
    #1;
    nCompared++;
    if ({out_isReady, out_last, out, in_canReceive} !== {1'b0, 1'b0, 16'h0000, 1'b1}) begin
      nMismatched++;
      $display("[TB] FAIL midrst_outputs: got valid=%b last=%b out=%h canRx=%b required 0,0,0000,1",
               out_isReady, out_last, out, in_canReceive);
    end
    sbQ.delete();
    modelCnt = 0;
    @(negedge clk);
    #2 rst = 1'b1;
    tick();
    inWord = wE;
    inIsReady = 1'b1;
    waitAccept(ok);
    inIsReady = 1'b0;
    @(negedge clk);
    nCompared++;
    if ({out_isReady, out} !== {1'b1, modelLane(wE, 0)}) begin
      nMismatched++;
      $display("[TB] FAIL midrst_lane0: got valid=%b out=%h required valid=1 out=%h", out_isReady, out, modelLane(wE, 0));
    end
    tick();
    drain(ok);
    nCompared++;
    if (ok !== 1'b1) begin nMismatched++; $display("[TB] FAIL midrst_drain: got %0d left required 0", sbQ.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_swap();
    test_frame_last();
    test_stall();
    test_clear();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
